// File: rtl/bus_master_if_if.sv
// Bus-side signal bundle between the CPU bus master and the interconnect.
// Ports: master drives addr/data/we/select, slave returns read data and ack.
interface bus_master_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 16
);
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_we_o;
    logic [SEL_W-1:0]  m_select_o;
    logic [DATA_W-1:0] m_data_i;
    logic              m_ack_i;

    modport master (
        output m_addr_o,
        output m_data_o,
        output m_we_o,
        output m_select_o,
        input  m_data_i,
        input  m_ack_i
    );

    modport slave (
        input  m_addr_o,
        input  m_data_o,
        input  m_we_o,
        input  m_select_o,
        output m_data_i,
        output m_ack_i
    );
endinterface

// File: rtl/bus_master_if.sv
// CPU-side single-word bus master: decodes region to one-hot select,
// drives registered bus cycle, stalls pipeline until ack/timeout/flush.
// Ports: clk, rst (sync, active-high); cpu_* request/response;
// stall_i/flush_i from pipeline control; m = bus master modport.
module bus_master_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              stallreq_o,
    output logic              err_o,
    input  logic              stall_i,
    input  logic              flush_i,
    bus_master_if_if.master   m
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] BUSY       = 2'd1;
    localparam logic [1:0] WAIT_STALL = 2'd2;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [3:0]        region;
    logic              legal;
    logic [SEL_W-1:0]  dec_sel;
    logic              to_hit;

    assign region = cpu_addr_i[ADDR_W-1 -: 4];
    assign legal  = ~region[3];
    assign to_hit = ~m.m_ack_i & (cnt_q == TO_LAST);

    always_comb begin
        dec_sel = '0;
        dec_sel[region[2:0]] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = we_q;
        sel_d      = sel_q;
        rbuf_d     = rbuf_q;
        cnt_d      = cnt_q;
        stallreq_o = 1'b0;
        err_o      = 1'b0;
        cpu_data_o = '0;
        unique case (state_q)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    if (legal) begin
                        stallreq_o = 1'b1;
                        addr_d     = cpu_addr_i;
                        data_d     = cpu_data_i;
                        we_d       = cpu_we_i;
                        sel_d      = dec_sel;
                        cnt_d      = '0;
                        state_d    = BUSY;
                    end else begin
                        err_o = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (flush_i) begin
                    addr_d  = '0;
                    data_d  = '0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    state_d = IDLE;
                end else if (m.m_ack_i || to_hit) begin
                    // Timeout completes like an ack carrying zero data.
                    err_o = to_hit;
                    if (m.m_ack_i && !we_q) cpu_data_o = m.m_data_i;
                    rbuf_d  = m.m_ack_i ? m.m_data_i : '0;
                    addr_d  = '0;
                    data_d  = '0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    state_d = stall_i ? WAIT_STALL : IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rbuf_q;
                if (!stall_i || flush_i) state_d = IDLE;
            end
            default: begin
                addr_d  = '0;
                data_d  = '0;
                we_d    = 1'b0;
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rbuf_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rbuf_q  <= rbuf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m.m_addr_o   = addr_q;
    assign m.m_data_o   = data_q;
    assign m.m_we_o     = we_q;
    assign m.m_select_o = sel_q;
endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if with a response scoreboard.
// Ports: drives cpu/pipeline inputs and plays the bus slave.
module tb_bus_master_if;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce, cpu_we, stall, flush;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stallreq, err;

    int n_tot  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          lat;
    } exp_t;
    exp_t sb[$];

    bus_master_if_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(16)) bus ();

    bus_master_if #(
        .ADDR_W(32), .DATA_W(32), .SEL_W(16), .TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce),
        .cpu_we_i   (cpu_we),
        .cpu_addr_i (cpu_addr),
        .cpu_data_i (cpu_wdata),
        .cpu_data_o (cpu_rdata),
        .stallreq_o (stallreq),
        .err_o      (err),
        .stall_i    (stall),
        .flush_i    (flush),
        .m          (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_sel"}, bus.m_select_o, 16'h0);
        chk({tag, "_addr"}, bus.m_addr_o, 32'h0);
        chk({tag, "_we"}, bus.m_we_o, 1'b0);
        chk({tag, "_wd"}, bus.m_data_o, 32'h0);
    endtask

    // k = BUSY cycle carrying ack (0 = never); nst = WAIT_STALL cycles.
    task automatic xfer(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input int k,
                        input logic [31:0] rd, input int nst);
        logic [15:0] es;
        logic [2:0]  r;
        exp_t        e, got;
        logic        done;
        r     = a[30:28];
        es    = 16'h0;
        es[r] = 1'b1;
        e.e   = (k == 0) || (k > 8);
        e.lat = e.e ? 8 : k;
        e.d   = (e.e || we) ? 32'h0 : rd;
        sb.push_back(e);
        cpu_ce = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        stall  = (nst > 0);
        #1;
        chk("req_stall", stallreq, 1'b1);
        chk("req_err", err, 1'b0);
        chk("req_sel", bus.m_select_o, 16'h0);
        tick();
        cpu_ce = 1'b0; cpu_addr = 32'hF000_0000; cpu_wdata = 32'h0;
        done = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i == k) begin
                bus.m_ack_i  = 1'b1;
                bus.m_data_i = rd;
            end
            #1;
            if (!stallreq) begin
                got = sb.pop_front();
                chk("rsp_data", cpu_rdata, got.d);
                chk("rsp_err", err, got.e);
                chk("rsp_lat", i, got.lat);
                done = 1'b1;
            end else begin
                chk("bus_sel", bus.m_select_o, es);
                chk("bus_addr", bus.m_addr_o, a);
                chk("bus_we", bus.m_we_o, we);
                chk("bus_wd", bus.m_data_o, wd);
            end
            tick();
            bus.m_ack_i  = 1'b0;
            bus.m_data_i = $urandom;
            if (done) break;
        end
        if (!done) chk("rsp_bound", 1'b0, 1'b1);
        for (int j = 1; j <= nst; j++) begin
            if (j == nst) stall = 1'b0;
            #1;
            chk("wait_data", cpu_rdata, e.d);
            chk("wait_stall", stallreq, 1'b0);
            chk("wait_sel", bus.m_select_o, 16'h0);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("post_rd", cpu_rdata, 32'h0);
        chk("post_stall", stallreq, 1'b0);
        chk_idle_bus("post");
        tick();
    endtask

    task automatic illegal(input logic [31:0] a);
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        #1;
        chk("ill_err", err, 1'b1);
        chk("ill_stall", stallreq, 1'b0);
        chk("ill_rd", cpu_rdata, 32'h0);
        tick();
        cpu_ce = 1'b0;
        #1;
        chk("ill_err_next", err, 1'b0);
        chk_idle_bus("ill");
        tick();
    endtask

    initial begin
        rst = 1'b1; cpu_ce = 1'b0; cpu_we = 1'b0; stall = 1'b0;
        flush = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bus.m_ack_i = 1'b0; bus.m_data_i = 32'h0;
        tick();
        tick();
        chk("rst_rd", cpu_rdata, 32'h0);
        chk("rst_stall", stallreq, 1'b0);
        chk("rst_err", err, 1'b0);
        chk_idle_bus("rst");
        rst = 1'b0;
        tick();

        // Load, ack on third BUSY cycle.
        xfer(1'b0, 32'h2000_0010, 32'h0, 3, 32'hDEAD_BEEF, 0);
        // Store to s7; returned data must be 0.
        xfer(1'b1, 32'h7000_0004, 32'h1234_5678, 2, 32'hCAFE_F00D, 0);
        // Region 0, best-case latency.
        xfer(1'b0, 32'h0FFF_FFFC, 32'h0, 1, 32'hA5A5_0001, 0);
        // Illegal regions, including the first illegal one.
        illegal(32'h9000_0000);
        illegal(32'h8FFF_FFFF);
        // Timeout with no ack.
        xfer(1'b0, 32'h3000_0000, 32'h0, 0, 32'h0, 0);
        // Ack while stalled; 3 WAIT_STALL cycles.
        xfer(1'b0, 32'h5000_0040, 32'h0, 2, 32'h0BAD_F00D, 3);
        // Timeout while stalled: buffer holds 0.
        xfer(1'b0, 32'h6000_0000, 32'h0, 0, 32'h0, 2);

        // Flush coincident with ack, stall_i high.
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000_0000;
        tick();
        cpu_ce = 1'b0;
        #1;
        chk("fl_sel", bus.m_select_o, 16'h0002);
        tick();
        flush = 1'b1; stall = 1'b1;
        bus.m_ack_i = 1'b1; bus.m_data_i = 32'h5555_5555;
        #1;
        chk("fl_stall", stallreq, 1'b0);
        chk("fl_err", err, 1'b0);
        chk("fl_rd", cpu_rdata, 32'h0);
        tick();
        flush = 1'b0; bus.m_ack_i = 1'b0;
        #1;
        chk("fl_next_rd", cpu_rdata, 32'h0);
        chk_idle_bus("fl");
        stall = 1'b0;
        // Flush suppresses an illegal request's error in IDLE.
        cpu_ce = 1'b1; cpu_addr = 32'hC000_0000; flush = 1'b1;
        #1;
        chk("fl_ill_err", err, 1'b0);
        tick();
        cpu_ce = 1'b0; flush = 1'b0;
        tick();

        // Reset while BUSY.
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4000_0008;
        cpu_wdata = 32'hFFFF_0000;
        tick();
        cpu_ce = 1'b0;
        #1;
        chk("rb_sel", bus.m_select_o, 16'h0010);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rb_stall", stallreq, 1'b0);
        chk("rb_err", err, 1'b0);
        chk("rb_rd", cpu_rdata, 32'h0);
        chk_idle_bus("rb");
        tick();

        // Back to normal operation after reset.
        xfer(1'b0, 32'h4000_0000, 32'h0, 4, 32'h0102_0304, 0);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
